// File: rtl/fan_ctrl_pkg.sv
// fan_ctrl_pkg
//   Shared definitions for the fan PWM generator: the fan FSM state encoding
//   and the default values of the block parameters.
package fan_ctrl_pkg;

  // Fan spin state. OFF = not driven, KICK = full-duty spin-up,
  // RUN = duty follows the PID controller.
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_KICK = 2'd1,
    ST_RUN  = 2'd2
  } fan_state_e;

  localparam int DEF_ADC_BITWIDTH = 8;
  localparam int DEF_PWM_BITWIDTH = 8;
  localparam int DEF_KICK_PERIODS = 4;
  localparam int DEF_MIN_DUTY     = 32;

endpackage : fan_ctrl_pkg

// File: rtl/pwm_period_counter.sv
// pwm_period_counter
//   Tick counter for one PWM period of 2^PWM_BITWIDTH-1 ticks. The counter
//   runs 0 .. PERIOD-1 and advances only on enabled ticks.
// Ports
//   clk_i     in   system clock
//   rstn_i    in   asynchronous active-low reset
//   clk_en_i  in   tick enable
//   cnt_o     out  current tick count
//   wrap_o    out  combinational: this edge takes the counter from PERIOD-1 to 0
//   strb_o    out  registered: high for the one clk after each wrap
module pwm_period_counter
  import fan_ctrl_pkg::*;
#(
  parameter int PWM_BITWIDTH = DEF_PWM_BITWIDTH
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    clk_en_i,
  output logic [PWM_BITWIDTH-1:0] cnt_o,
  output logic                    wrap_o,
  output logic                    strb_o
);

  // PERIOD-1 = 2^N-2: all ones except the LSB.
  localparam logic [PWM_BITWIDTH-1:0] LAST_CNT = {{(PWM_BITWIDTH-1){1'b1}}, 1'b0};

  logic [PWM_BITWIDTH-1:0] cnt_q;
  logic                    strb_q;

  assign wrap_o = clk_en_i && (cnt_q == LAST_CNT);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q  <= '0;
      strb_q <= 1'b0;
    end else begin
      strb_q <= wrap_o;
      if (clk_en_i) begin
        cnt_q <= wrap_o ? '0 : cnt_q + 1'b1;
      end
    end
  end

  assign cnt_o  = cnt_q;
  assign strb_o = strb_q;

endmodule : pwm_period_counter

// File: rtl/fan_pwm_gen.sv
// fan_pwm_gen
//   PWM generator for a cooling fan driven by a PID controller output.
//   A spin-up from standstill is preceded by KICK_PERIODS periods at 100%
//   duty; afterwards the duty follows the PID value, floored at MIN_DUTY.
//   State and duty only change at period wraps, so every period is a clean
//   high-then-low pulse.
// Ports
//   clk_i          in   system clock
//   rstn_i         in   asynchronous active-low reset
//   clk_en_PWM_i   in   tick enable for the period counter
//   enable_i       in   fan enable; low forces OFF at the next wrap
//   PID_value_i    in   signed PID output, ADC_BITWIDTH+1 bits
//   pwm_o          out  registered PWM drive
//   period_STRB_o  out  one-clk strobe after each wrap (PID clock enable)
//   duty_o         out  applied duty
//   kick_active_o  out  high while in KICK
//   fsm_state_o    out  raw FSM state (fan_state_e encoding) for debug
module fan_pwm_gen
  import fan_ctrl_pkg::*;
#(
  parameter int ADC_BITWIDTH = DEF_ADC_BITWIDTH,
  parameter int PWM_BITWIDTH = DEF_PWM_BITWIDTH,
  parameter int KICK_PERIODS = DEF_KICK_PERIODS,
  parameter int MIN_DUTY     = DEF_MIN_DUTY
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    clk_en_PWM_i,
  input  logic                    enable_i,
  input  logic [ADC_BITWIDTH:0]   PID_value_i,
  output logic                    pwm_o,
  output logic                    period_STRB_o,
  output logic [PWM_BITWIDTH-1:0] duty_o,
  output logic                    kick_active_o,
  output logic [1:0]              fsm_state_o
);

  localparam int KW = $clog2(KICK_PERIODS + 1);
  localparam logic [KW-1:0]           KICK_INIT = KW'(KICK_PERIODS);
  localparam logic [KW-1:0]           KICK_LAST = KW'(1);
  // PERIOD = 2^N-1 is all ones: cnt never reaches it, so pwm stays high.
  localparam logic [PWM_BITWIDTH-1:0] FULL_DUTY = '1;
  localparam logic [PWM_BITWIDTH-1:0] MIN_D     = PWM_BITWIDTH'(MIN_DUTY);

  logic [PWM_BITWIDTH-1:0] cnt;
  logic                    wrap;

  pwm_period_counter #(
    .PWM_BITWIDTH (PWM_BITWIDTH)
  ) u_period (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .clk_en_i (clk_en_PWM_i),
    .cnt_o    (cnt),
    .wrap_o   (wrap),
    .strb_o   (period_STRB_o)
  );

  // Target duty from the PID value. The magnitude is zero-extended then
  // cut to PWM_BITWIDTH, which works for either width ordering.
  logic [ADC_BITWIDTH+PWM_BITWIDTH-1:0] mag_wide;
  logic [PWM_BITWIDTH-1:0]              mag;
  logic                                 pid_pos;
  logic [PWM_BITWIDTH-1:0]              target;

  assign mag_wide = {{PWM_BITWIDTH{1'b0}}, PID_value_i[ADC_BITWIDTH-1:0]};
  assign mag      = mag_wide[PWM_BITWIDTH-1:0];
  assign pid_pos  = !PID_value_i[ADC_BITWIDTH] && (PID_value_i[ADC_BITWIDTH-1:0] != '0);

  always_comb begin
    target = '0;
    if (pid_pos && (mag != '0)) begin
      target = (mag < MIN_D) ? MIN_D : mag;
    end
  end

  fan_state_e              state_q;
  logic [KW-1:0]           kick_cnt_q;
  logic [PWM_BITWIDTH-1:0] duty_q;
  logic                    pwm_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_OFF;
      kick_cnt_q <= '0;
      duty_q     <= '0;
      pwm_q      <= 1'b0;
    end else begin
      pwm_q <= (cnt < duty_q);
      if (wrap) begin
        if (!enable_i) begin
          // Disable wins over every other transition.
          state_q    <= ST_OFF;
          kick_cnt_q <= '0;
          duty_q     <= '0;
        end else begin
          case (state_q)
            ST_OFF: begin
              if (target != '0) begin
                state_q    <= ST_KICK;
                kick_cnt_q <= KICK_INIT;
                duty_q     <= FULL_DUTY;
              end else begin
                duty_q <= '0;
              end
            end
            ST_KICK: begin
              if (target == '0) begin
                state_q    <= ST_OFF;
                kick_cnt_q <= '0;
                duty_q     <= '0;
              end else if (kick_cnt_q == KICK_LAST) begin
                state_q    <= ST_RUN;
                kick_cnt_q <= '0;
                duty_q     <= target;
              end else begin
                kick_cnt_q <= kick_cnt_q - 1'b1;
                duty_q     <= FULL_DUTY;
              end
            end
            ST_RUN: begin
              if (target == '0) begin
                state_q <= ST_OFF;
                duty_q  <= '0;
              end else begin
                duty_q <= target;
              end
            end
            default: begin
              state_q    <= ST_OFF;
              kick_cnt_q <= '0;
              duty_q     <= '0;
            end
          endcase
        end
      end
    end
  end

  assign pwm_o         = pwm_q;
  assign duty_o        = duty_q;
  assign kick_active_o = (state_q == ST_KICK);
  assign fsm_state_o   = state_q;

endmodule : fan_pwm_gen

// File: doc/fan_pwm_gen.md
FAN_PWM_GEN -- requirements
Module: fan_pwm_gen

Interface
REQ-001 Parameter ADC_BITWIDTH, default 8: magnitude width of the PID controller output.
REQ-002 Parameter PWM_BITWIDTH, default 8: duty resolution; PERIOD = 2^PWM_BITWIDTH-1 ticks.
REQ-003 Parameter KICK_PERIODS, default 4: full PWM periods of 100% duty on fan spin-up.
REQ-004 Parameter MIN_DUTY, default 32: lowest non-zero duty applied in RUN.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk_i  input  1  system clock, all state on rising edge.
REQ-007 rstn_i  input  1  asynchronous active-low reset.
REQ-008 clk_en_PWM_i  input  1  tick enable; counter advances only when high.
REQ-009 enable_i  input  1  fan enable; low forces OFF at next period wrap.
REQ-010 PID_value_i  input  ADC_BITWIDTH+1  signed PID controller output, two's complement.
REQ-011 pwm_o  output  1  registered PWM drive to the fan.
REQ-012 period_STRB_o  output  1  one-clk strobe per period wrap; drives the PID controller's clk_en_PID_i.
REQ-013 duty_o  output  PWM_BITWIDTH  duty currently applied.
REQ-014 kick_active_o  output  1  high while state is KICK.

Function
REQ-015 Tick counter cnt SHALL count 0..PERIOD-1, advancing by 1 on each clk with clk_en_PWM_i high, and wrap to 0 after PERIOD-1 (wrap event).
REQ-016 period_STRB_o SHALL be high for exactly the one clk cycle following each wrap event, low otherwise.
REQ-017 Target duty SHALL be: 0 if PID_value_i negative or zero; else PID_value_i[ADC_BITWIDTH-1:0], resized to PWM_BITWIDTH; raised to MIN_DUTY if non-zero and below MIN_DUTY.
REQ-018 Applied duty SHALL change only at a wrap event; PID_value_i changes mid-period SHALL have no effect until the next wrap.
REQ-019 pwm_o SHALL equal the registered value of (cnt < applied duty), one clk latency; duty 0 gives constant low, duty PERIOD gives constant high.
REQ-020 FSM states OFF, KICK, RUN; all transitions evaluated only at wrap events.
REQ-021 OFF: if enable_i high and target non-zero -> KICK, kick counter := KICK_PERIODS, duty := PERIOD; else stay, duty 0.
REQ-022 KICK: kick counter decrements each wrap; duty held at PERIOD; when counter equals 1 at a wrap -> RUN with duty := target.
REQ-023 RUN: duty := target each wrap; if target is 0 -> OFF, duty 0.
REQ-024 enable_i low at a wrap SHALL force OFF with duty 0 from any state, overriding all other transitions.
REQ-025 KICK with target 0 at a wrap SHALL go to OFF.
REQ-026 duty_o SHALL equal the applied duty register; kick_active_o SHALL be a decode of the state register.

Reset
REQ-027 rstn_i low SHALL asynchronously clear cnt, kick counter, duty, pwm_o, period_STRB_o, kick_active_o to 0 and state to OFF.
REQ-028 Reset asserted mid-KICK or mid-period SHALL abort it; after release a new spin-up SHALL start with a full KICK_PERIODS kick.

Structure
REQ-029 FSM state encoding and default parameter constants SHALL reside in shared package fan_ctrl_pkg.
REQ-030 Tick counter and wrap/strobe logic SHALL be sub-module pwm_period_counter; FSM and duty logic stay in fan_pwm_gen.

Verification (defaults, clk_en_PWM_i constantly high unless stated)
REQ-031 enable_i=1, PID_value_i=+128 from reset -> pwm_o high 1020 clks with kick_active_o=1, then 128 high / 127 low per 255-clk period, duty_o=128.
REQ-032 In RUN, PID_value_i=-5 -> at next wrap duty_o=0, state OFF, pwm_o constant low.
REQ-033 In RUN, PID_value_i=+10 -> duty_o=32 after next wrap; PID_value_i=+255 -> pwm_o constant high.
REQ-034 PID_value_i changed +64 -> +200 at mid-period -> duty_o stays 64 until the wrap, then 200.
REQ-035 rstn_i pulsed low during second kick period -> all outputs 0 immediately; after release, a fresh 4-period kick.
REQ-036 clk_en_PWM_i high every 4th clk -> period_STRB_o one clk wide, every 1020 clks.
